// File: rtl/clk_rst_pkg.sv
// Shared state encodings, default timing constants and helpers for the clock/reset sequencer.
// StSoft exists only when CLK_RST_SOFT_RESET_EN is defined.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        StMgrRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelIo    = 3'd3,
        StRelCore  = 3'd4,
        StRelDbg   = 3'd5,
`ifdef CLK_RST_SOFT_RESET_EN
        StRun      = 3'd6,
        StSoft     = 3'd7
`else
        StRun      = 3'd6
`endif
    } seq_state_e;

    localparam int unsigned DefSyncStages       = 2;
    localparam int unsigned DefLockStableCycles = 1024;
    localparam int unsigned DefLockTimeoutCycles = 65536;
    localparam int unsigned DefMgrRstCycles     = 16;
    localparam int unsigned DefStageGap         = 8;
    localparam int unsigned DefRetryW           = 4;

    function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchroniser for a single asynchronous level, cleared to 0 by the async reset.
module lock_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_reset_sequencer.sv
// Clock-manager bring-up: lock wait with retry, stable window, ordered domain reset release.
// Optional soft-reset path is built when CLK_RST_SOFT_RESET_EN is defined.
module clk_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = DefSyncStages,
    parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
    parameter int unsigned MGR_RST_CYCLES      = DefMgrRstCycles,
    parameter int unsigned STAGE_GAP           = DefStageGap,
    parameter int unsigned RETRY_W             = DefRetryW
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               locked_i,
`ifdef CLK_RST_SOFT_RESET_EN
    input  logic               soft_reset_req_i,
`endif
    output logic               mgr_reset_o,
    output logic               io_reset_o,
    output logic               core_reset_o,
    output logic               dbg_reset_o,
    output logic               ready_o,
    output logic [2:0]         seq_state_o,
    output logic [RETRY_W-1:0] retry_cnt_o
);

    localparam int unsigned CntMax = max_of4(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                             MGR_RST_CYCLES, STAGE_GAP);
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t MgrLoad     = cnt_t'(MGR_RST_CYCLES - 1);
    localparam cnt_t TimeoutLoad = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
    localparam cnt_t StableLoad  = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t GapLoad     = cnt_t'(STAGE_GAP - 1);

    seq_state_e         state_q, state_d;
    cnt_t               cnt_q, cnt_d, cnt_load;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               mgr_q, io_q, core_q, dbg_q;
    logic               mgr_d, io_d, core_d, dbg_d;
    logic               lk;
    logic               cnt_zero;
    logic               lock_loss;

    lock_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i(clk_i),
        .rst_i(reset_i),
        .d_i  (locked_i),
        .q_o  (lk)
    );

`ifdef CLK_RST_SOFT_RESET_EN
    logic soft_req;

    lock_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_soft_sync (
        .clk_i(clk_i),
        .rst_i(reset_i),
        .d_i  (soft_reset_req_i),
        .q_o  (soft_req)
    );
`endif

    assign cnt_zero  = (cnt_q == '0);
    assign lock_loss = !lk && (state_q inside {StRelIo, StRelCore, StRelDbg, StRun});

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        unique case (state_q)
            StMgrRst: begin
                if (cnt_zero) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lk) begin
                    state_d = StStable;
                end else if (cnt_zero) begin
                    state_d = StMgrRst;
                    if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
                end
            end
            StStable: begin
                if (!lk) state_d = StWaitLock;
                else if (cnt_zero) state_d = StRelIo;
            end
            StRelIo: begin
                if (!lk) state_d = StWaitLock;
                else if (cnt_zero) state_d = StRelCore;
            end
            StRelCore: begin
                if (!lk) state_d = StWaitLock;
                else if (cnt_zero) state_d = StRelDbg;
            end
            StRelDbg: begin
                if (!lk) state_d = StWaitLock;
                else if (cnt_zero) state_d = StRun;
            end
            StRun: begin
                if (!lk) state_d = StWaitLock;
            end
`ifdef CLK_RST_SOFT_RESET_EN
            StSoft: begin
                if (!lk) state_d = StWaitLock;
                else if (cnt_zero) state_d = StRelIo;
            end
`endif
            default: state_d = StMgrRst;
        endcase
`ifdef CLK_RST_SOFT_RESET_EN
        // Soft request overrides stage advance but never a lock loss.
        if (soft_req && lk && (state_q inside {StRelIo, StRelCore, StRelDbg, StRun})) begin
            state_d = StSoft;
        end
`endif
    end

    always_comb begin
        cnt_load = GapLoad;
        case (state_d)
            StMgrRst:   cnt_load = MgrLoad;
            StWaitLock: cnt_load = TimeoutLoad;
            StStable:   cnt_load = StableLoad;
            default:    cnt_load = GapLoad;
        endcase
        if (state_d != state_q) cnt_d = cnt_load;
        else if (cnt_zero)      cnt_d = cnt_q;
        else                    cnt_d = cnt_q - cnt_t'(1);
    end

    // Resets are registered from the next state so each falls on the first cycle of its stage.
    always_comb begin
        mgr_d  = (state_d == StMgrRst);
        io_d   = !(state_d inside {StRelIo, StRelCore, StRelDbg, StRun});
        core_d = !(state_d inside {StRelCore, StRelDbg, StRun});
        dbg_d  = !(state_d inside {StRelDbg, StRun});
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StMgrRst;
            cnt_q   <= MgrLoad;
            retry_q <= '0;
            mgr_q   <= 1'b1;
            io_q    <= 1'b1;
            core_q  <= 1'b1;
            dbg_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            mgr_q   <= mgr_d;
            io_q    <= io_d;
            core_q  <= core_d;
            dbg_q   <= dbg_d;
        end
    end

    assign mgr_reset_o  = mgr_q;
    assign io_reset_o   = io_q | lock_loss;
    assign core_reset_o = core_q | lock_loss;
    assign dbg_reset_o  = dbg_q | lock_loss;
    assign ready_o      = (state_q == StRun) && lk;
    assign seq_state_o  = state_q;
    assign retry_cnt_o  = retry_q;

endmodule
